// File: rtl/minterm_table_scanner.sv
// ----------------------------------------------------------------------------
// minterm_table_scanner
//
// Sequential truth-table generator for an N_IN-input sum-of-minterms function.
// The minterm set is a runtime mask that is captured when a scan starts. A
// scan walks all 2^N_IN input combinations and streams one (vars, s) row per
// accepted beat over a valid/ready handshake. It also counts the accepted
// rows whose function value is 1.
//
// Optional feature macro: GRAY_ORDER_EN
//   defined   : rows are emitted in reflected Gray order (vars = idx ^ idx>>1),
//               so consecutive rows differ in exactly one bit.
//   undefined : rows are emitted in ascending binary order (vars = idx).
//
// Parameters
//   N_IN            number of function inputs (1..8); vars[N_IN-1] is the MSB
//
// Ports
//   i_clk           rising-edge clock
//   i_reset         synchronous, active-high reset
//   i_start         begin a scan (sampled only while idle)
//   i_minterm_mask  bit k=1 -> minterm k is in the function (latched at start)
//   i_out_ready     consumer accepts the current row
//   o_out_valid     current row valid
//   o_out_vars      input combination of the current row
//   o_out_s         function value for o_out_vars
//   o_busy          high while scanning and during the done cycle
//   o_done          one-cycle pulse after the last row is accepted
//   o_ones_count    accepted rows with s=1 in the current/last scan
// ----------------------------------------------------------------------------
module minterm_table_scanner #(
   parameter int N_IN = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [(1<<N_IN)-1:0]  i_minterm_mask,
   input  logic                  i_out_ready,
   output logic                  o_out_valid,
   output logic [N_IN-1:0]       o_out_vars,
   output logic                  o_out_s,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [N_IN:0]         o_ones_count
);

   localparam int M_W = 1 << N_IN;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [N_IN-1:0]   r_idx;
   logic [M_W-1:0]    r_mask;
   logic [N_IN:0]     r_ones;
   logic              r_valid;
   logic              r_busy;
   logic              r_done;

   logic [N_IN-1:0]   w_vars;
   logic              w_mask_bit;
   logic              w_last;
   logic              w_accept;

   // Row ordering: the scan index always counts in binary; only the
   // presented combination changes with the ordering option.
`ifdef GRAY_ORDER_EN
   assign w_vars = r_idx ^ (r_idx >> 1);
`else
   assign w_vars = r_idx;
`endif

   assign w_mask_bit = r_mask[w_vars];
   assign w_last     = &r_idx;
   assign w_accept   = r_valid & i_out_ready;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_mask  <= '0;
         r_ones  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_mask  <= i_minterm_mask;
                  r_idx   <= '0;
                  r_ones  <= '0;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (w_accept) begin
                  r_ones <= r_ones + (N_IN+1)'(w_mask_bit);
                  if (w_last) begin
                     // Index wraps back to 0 so the idle output reads as row 0.
                     r_idx   <= '0;
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_idx <= r_idx + N_IN'(1);
                  end
               end
            end
            S_DONE: begin
               // Start is deliberately not sampled here.
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign o_out_valid  = r_valid;
   assign o_out_vars   = w_vars;
   // Function value is only meaningful on a valid row; forced low otherwise.
   assign o_out_s      = r_valid & w_mask_bit;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_ones_count = r_ones;

endmodule

// File: tb/tb_minterm_table_scanner.sv
module tb_minterm_table_scanner;

   logic        clk;
   logic        reset;

   // N_IN = 4 instance
   logic        st;
   logic [15:0] mask;
   logic        rdy;
   logic        valid;
   logic [3:0]  vars;
   logic        s;
   logic        busy;
   logic        done;
   logic [4:0]  ones_count;

   // N_IN = 2 instance
   logic        b_st;
   logic [3:0]  b_mask;
   logic        b_rdy;
   logic        b_valid;
   logic [1:0]  b_vars;
   logic        b_s;
   logic        b_busy;
   logic        b_done;
   logic [2:0]  b_ones;

   int checks = 0;
   int errors = 0;

   minterm_table_scanner #(.N_IN(4)) dut4 (
      .i_clk(clk), .i_reset(reset), .i_start(st), .i_minterm_mask(mask),
      .i_out_ready(rdy), .o_out_valid(valid), .o_out_vars(vars), .o_out_s(s),
      .o_busy(busy), .o_done(done), .o_ones_count(ones_count)
   );

   minterm_table_scanner #(.N_IN(2)) dut2 (
      .i_clk(clk), .i_reset(reset), .i_start(b_st), .i_minterm_mask(b_mask),
      .i_out_ready(b_rdy), .o_out_valid(b_valid), .o_out_vars(b_vars), .o_out_s(b_s),
      .o_busy(b_busy), .o_done(b_done), .o_ones_count(b_ones)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ordering: the i-th row of a scan.
   function automatic int row_vars(input int i);
`ifdef GRAY_ORDER_EN
      return i ^ (i >> 1);
`else
      return i;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full scan of the N_IN=4 instance. mode 0: ready always 1,
   // mode 1: ready 1,0,0,1,0,0..., mode 2: random ready.
   // Mid-scan a start pulse and an inverted mask are applied; both must be ignored.
   task automatic scan4(input logic [15:0] m, input int mode, input string tag);
      int row, cyc, ones, v;
      logic r;
      @(negedge clk);
      st = 1'b1; mask = m;
      @(negedge clk);
      st = 1'b0;
      row = 0; cyc = 0; ones = 0;
      while (row < 16 && cyc < 200) begin
         case (mode)
            0:       r = 1'b1;
            1:       r = (cyc % 3 == 0);
            default: r = 1'($urandom_range(0, 1));
         endcase
         rdy = r;
         v = row_vars(row);
         chk({tag, "_valid"}, 32'(valid), 32'd1);
         chk({tag, "_vars"},  32'(vars),  32'(v));
         chk({tag, "_s"},     32'(s),     32'(m[v]));
         chk({tag, "_busy"},  32'(busy),  32'd1);
         chk({tag, "_done"},  32'(done),  32'd0);
         chk({tag, "_ones_run"}, 32'(ones_count), 32'(ones));
         if (cyc == 2) begin
            st = 1'b1; mask = ~m;
         end else begin
            st = 1'b0;
         end
         if (r) begin
            ones += int'(m[v]);
            row++;
         end
         cyc++;
         @(negedge clk);
      end
      st = 1'b0;
      chk({tag, "_rows_seen"}, 32'(row), 32'd16);
      if (mode == 0) chk({tag, "_length"}, 32'(cyc), 32'd16);
      chk({tag, "_done_pulse"}, 32'(done),  32'd1);
      chk({tag, "_done_valid"}, 32'(valid), 32'd0);
      chk({tag, "_done_busy"},  32'(busy),  32'd1);
      chk({tag, "_ones_final"}, 32'(ones_count), 32'($countones(m)));
      @(negedge clk);
      chk({tag, "_idle_done"},  32'(done), 32'd0);
      chk({tag, "_idle_busy"},  32'(busy), 32'd0);
      chk({tag, "_idle_valid"}, 32'(valid), 32'd0);
      chk({tag, "_ones_hold"},  32'(ones_count), 32'($countones(m)));
   endtask

   initial begin
      logic [15:0] rm;
      reset = 1'b1;
      st = 1'b0; mask = 16'h0; rdy = 1'b0;
      b_st = 1'b0; b_mask = 4'h0; b_rdy = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Reset state
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_vars",  32'(vars),  32'd0);
      chk("rst_s",     32'(s),     32'd0);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_done",  32'(done),  32'd0);
      chk("rst_ones",  32'(ones_count), 32'd0);

      // Reset mid-scan after row 5 accepted
      st = 1'b1; mask = 16'hFFFF; rdy = 1'b1;
      @(negedge clk);
      st = 1'b0;
      repeat (6) @(negedge clk);
      chk("t1_row6", 32'(vars), 32'(row_vars(6)));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t1_valid", 32'(valid), 32'd0);
      chk("t1_vars",  32'(vars),  32'd0);
      chk("t1_s",     32'(s),     32'd0);
      chk("t1_busy",  32'(busy),  32'd0);
      chk("t1_done",  32'(done),  32'd0);
      chk("t1_ones",  32'(ones_count), 32'd0);
      @(negedge clk);
      chk("t1_nodone", 32'(done), 32'd0);
      chk("t1_idle",   32'(busy), 32'd0);

      // Directed scans
      scan4(16'h5516, 0, "t2");
      scan4(16'h5516, 1, "t3");
      scan4(16'hFFFF, 0, "t4_all");
      chk("t4_ones16", 32'(ones_count), 32'h10);
      scan4(16'h0000, 0, "t4_none");

      // Random masks with random back-pressure
      for (int k = 0; k < 4; k++) begin
         rm = 16'($urandom);
         scan4(rm, 2, "rnd");
      end

      // N_IN=2 AND function, plus start held through the done cycle
      @(negedge clk);
      b_st = 1'b1; b_mask = 4'b1000; b_rdy = 1'b1;
      @(negedge clk);
      b_st = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t5_valid", 32'(b_valid), 32'd1);
         chk("t5_vars",  32'(b_vars),  32'(row_vars(i)));
         chk("t5_s",     32'(b_s),     32'(row_vars(i) == 3));
         if (i == 3) begin
            b_st = 1'b1; b_mask = 4'b0110;
         end
         @(negedge clk);
      end
      chk("t5_done", 32'(b_done), 32'd1);
      chk("t5_ones", 32'(b_ones), 32'd1);
      @(negedge clk);
      chk("t5_start_in_done_ignored", 32'(b_busy), 32'd0);
      chk("t5_idle_valid", 32'(b_valid), 32'd0);
      @(negedge clk);
      b_st = 1'b0;
      chk("t5_restart_busy",  32'(b_busy),  32'd1);
      chk("t5_restart_valid", 32'(b_valid), 32'd1);
      chk("t5_restart_vars",  32'(b_vars),  32'd0);
      repeat (4) @(negedge clk);
      chk("t5_restart_done", 32'(b_done), 32'd1);
      chk("t5_restart_ones", 32'(b_ones), 32'd2);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
